// File: rtl/fifo_rd_ctrl_gather_pkg.sv
// Shared definitions for the gathering FIFO read controller: state encoding,
// width derivations and parameter legality checks.
package fifo_rd_ctrl_gather_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } rd_state_e;

  // Memory words packed into one output word.
  function automatic int calc_ratio(input int r_data_width, input int mem_width);
    return (mem_width > 0) ? (r_data_width / mem_width) : 0;
  endfunction

  // Pointers carry one extra wrap bit above the address.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

  function automatic bit params_legal(input int r_data_width, input int mem_width,
                                      input int addr_width, input int fifo_depth);
    int ratio;
    if (mem_width <= 0 || r_data_width <= 0) return 1'b0;
    if (r_data_width % mem_width != 0) return 1'b0;
    ratio = r_data_width / mem_width;
    if (fifo_depth % ratio != 0) return 1'b0;
    return fifo_depth == (1 << addr_width);
  endfunction

endpackage

// File: rtl/fifo_gather_shreg.sv
// Pack register: drops each captured memory word into the next slot, first
// word in the LSBs, and pulses done on the capture that fills the last slot.
module fifo_gather_shreg #(
  parameter int MEM_WIDTH = 16,
  parameter int RATIO     = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       capture,
  input  logic [MEM_WIDTH-1:0]       mem_data,
  output logic [RATIO*MEM_WIDTH-1:0] pack,
  output logic                       done
);

  localparam int SLOT_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(RATIO - 1);

  logic [SLOT_W-1:0] slot;

  assign done = capture && (slot == LAST_SLOT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      slot <= '0;
      pack <= '0;
    end else if (capture) begin
      pack[slot*MEM_WIDTH +: MEM_WIDTH] <= mem_data;
      slot <= done ? '0 : slot + SLOT_W'(1);
    end
  end

endmodule

// File: rtl/fifo_rd_ctrl_gather.sv
// Read-side controller for the PE scratch FIFOs: fetches RATIO memory words per
// output word and presents the packed result behind a valid/request handshake.
module fifo_rd_ctrl_gather
  import fifo_rd_ctrl_gather_pkg::*;
#(
  parameter int R_DATA_WIDTH = 64,
  parameter int MEM_WIDTH    = 16,
  parameter int ADDR_WIDTH   = 4,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ptr_width(ADDR_WIDTH)-1:0]   wr_ptr,
  output logic [ptr_width(ADDR_WIDTH)-1:0]   rd_ptr,
  output logic                               mem_rd_en,
  output logic [ADDR_WIDTH-1:0]              mem_rd_addr,
  input  logic [MEM_WIDTH-1:0]               mem_rd_data,
  output logic [R_DATA_WIDTH-1:0]            rd_data,
  output logic                               rd_valid,
  input  logic                               rd_request,
  output logic                               empty_flag,
  output logic [ptr_width(ADDR_WIDTH)-1:0]   fill_count
);

  localparam int RATIO = calc_ratio(R_DATA_WIDTH, MEM_WIDTH);
  localparam int PW    = ptr_width(ADDR_WIDTH);
  localparam int CNT_W = $clog2(RATIO + 1);

  if (!params_legal(R_DATA_WIDTH, MEM_WIDTH, ADDR_WIDTH, FIFO_DEPTH)) begin : g_param_check
    $error("fifo_rd_ctrl_gather: illegal parameter combination");
  end

  rd_state_e         state, state_next;
  logic [PW-1:0]     fetch_ptr;
  logic [PW-1:0]     avail;
  logic [CNT_W-1:0]  issue_cnt;
  logic              issue;
  logic              capture;
  logic              start;
  logic              can_start;
  logic              pop;
  logic              gather_done;

  // fetch_ptr runs ahead of rd_ptr by the words issued but not yet retired,
  // so measuring from it gives what is still free to fetch.
  assign avail      = wr_ptr - fetch_ptr;
  assign fill_count = wr_ptr - rd_ptr;
  assign empty_flag = (wr_ptr == rd_ptr);
  assign can_start  = (avail >= PW'(RATIO));
  assign pop        = rd_valid && rd_request;

  assign issue       = (state == FETCH) && (issue_cnt != CNT_W'(RATIO));
  assign mem_rd_en   = issue;
  assign mem_rd_addr = fetch_ptr[ADDR_WIDTH-1:0];

  // NOTE: every output of this block gets a default first, so no path
  // through the case leaves a variable unassigned and no latch is inferred.
  always_comb begin
    state_next = state;
    start      = 1'b0;
    unique case (state)
      IDLE: begin
        if (can_start && (!rd_valid || pop)) begin
          state_next = FETCH;
          start      = 1'b1;
        end
      end
      FETCH: begin
        if (gather_done) state_next = HOLD;
      end
      HOLD: begin
        if (pop) begin
          if (can_start) begin
            state_next = FETCH;
            start      = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_ptr <= '0;
      rd_ptr    <= '0;
      issue_cnt <= '0;
      capture   <= 1'b0;
      rd_valid  <= 1'b0;
    end else begin
      state   <= state_next;
      capture <= issue;
      if (start) begin
        issue_cnt <= '0;
      end else if (issue) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (issue) fetch_ptr <= fetch_ptr + PW'(1);
      // Retire on capture, not issue, so the writer cannot reuse the slot early.
      if (capture) rd_ptr <= rd_ptr + PW'(1);
      if (gather_done) begin
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

  fifo_gather_shreg #(
    .MEM_WIDTH (MEM_WIDTH),
    .RATIO     (RATIO)
  ) u_shreg (
    .clk      (clk),
    .reset    (reset),
    .capture  (capture),
    .mem_data (mem_rd_data),
    .pack     (rd_data),
    .done     (gather_done)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl_gather.sv
// Directed bench for fifo_rd_ctrl_gather: per-cycle vector table for reset,
// latency, threshold and mid-gather reset, plus hand sequences for streaming.
module tb_fifo_rd_ctrl_gather;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  wr_ptr;
  logic [4:0]  rd_ptr;
  logic        mem_rd_en;
  logic [3:0]  mem_rd_addr;
  logic [15:0] mem_rd_data;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_request;
  logic        empty_flag;
  logic [4:0]  fill_count;

  logic [15:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  fifo_rd_ctrl_gather #(
    .R_DATA_WIDTH (64),
    .MEM_WIDTH    (16),
    .ADDR_WIDTH   (4),
    .FIFO_DEPTH   (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .wr_ptr      (wr_ptr),
    .rd_ptr      (rd_ptr),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .rd_request  (rd_request),
    .empty_flag  (empty_flag),
    .fill_count  (fill_count)
  );

  always #5 clk = ~clk;

  // Synchronous-read scratch memory.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int          rst;
    int          wr;
    int          req;
    int          e_valid;
    int          e_rd_ptr;
    int          e_en;
    int          e_addr;
    int          e_fill;
    int          e_empty;
    int          chk_data;
    logic [63:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int rst, input int wr, input int req,
                              input int e_valid, input int e_rd_ptr, input int e_en,
                              input int e_addr, input int e_fill, input int e_empty,
                              input int chk_data, input logic [63:0] e_data);
    vec_t v;
    v.rst = rst; v.wr = wr; v.req = req;
    v.e_valid = e_valid; v.e_rd_ptr = e_rd_ptr; v.e_en = e_en; v.e_addr = e_addr;
    v.e_fill = e_fill; v.e_empty = e_empty; v.chk_data = chk_data; v.e_data = e_data;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Drive inputs away from the rising edge, let one edge pass, sample on the falling edge.
  task automatic step(input int r, input int w, input int q);
    reset      = r[0];
    wr_ptr     = 5'(w);
    rd_request = q[0];
    @(posedge clk);
    @(negedge clk);
  endtask

  localparam logic [63:0] W0 = 64'h4444_3333_2222_1111;
  localparam logic [63:0] W1 = 64'h8888_7777_6666_5555;

  initial begin
    int low;
    int n;
    int en_cnt;
    logic [3:0]  addrs[$];
    logic [63:0] words[$];
    logic [3:0]  exp_addr [12];
    logic [63:0] exp_word [3];

    for (int i = 0; i < 16; i++) mem[i] = 16'h0;
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    mem[4] = 16'h5555; mem[5] = 16'h6666; mem[6] = 16'h7777; mem[7] = 16'h8888;

    //                 rst wr req | vld rdp en addr fill emp chk data
    vecs.push_back(mk(1, 0, 0,     0,  0,  0, 0,   0,   1,  1,  64'h0));
    vecs.push_back(mk(0, 4, 0,     0,  0,  1, 0,   4,   0,  0,  64'h0));
    vecs.push_back(mk(0, 4, 0,     0,  0,  1, 1,   4,   0,  0,  64'h0));
    vecs.push_back(mk(0, 4, 0,     0,  1,  1, 2,   3,   0,  0,  64'h0));
    vecs.push_back(mk(0, 4, 0,     0,  2,  1, 3,   2,   0,  0,  64'h0));
    vecs.push_back(mk(0, 4, 0,     0,  3,  0, 4,   1,   0,  0,  64'h0));
    vecs.push_back(mk(0, 4, 0,     1,  4,  0, 4,   0,   1,  1,  W0));
    vecs.push_back(mk(0, 4, 0,     1,  4,  0, 4,   0,   1,  1,  W0));
    vecs.push_back(mk(0, 4, 1,     0,  4,  0, 4,   0,   1,  1,  W0));
    // below threshold, then threshold reached, then reset on the 3rd FETCH cycle
    vecs.push_back(mk(1, 0, 0,     0,  0,  0, 0,   0,   1,  1,  64'h0));
    vecs.push_back(mk(0, 3, 0,     0,  0,  0, 0,   3,   0,  0,  64'h0));
    vecs.push_back(mk(0, 3, 1,     0,  0,  0, 0,   3,   0,  0,  64'h0));
    vecs.push_back(mk(0, 4, 0,     0,  0,  1, 0,   4,   0,  0,  64'h0));
    vecs.push_back(mk(0, 4, 0,     0,  0,  1, 1,   4,   0,  0,  64'h0));
    vecs.push_back(mk(0, 4, 0,     0,  1,  1, 2,   3,   0,  0,  64'h0));
    vecs.push_back(mk(1, 0, 0,     0,  0,  0, 0,   0,   1,  1,  64'h0));
    vecs.push_back(mk(0, 0, 0,     0,  0,  0, 0,   0,   1,  1,  64'h0));
    vecs.push_back(mk(0, 0, 1,     0,  0,  0, 0,   0,   1,  1,  64'h0));

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].req);
      check($sformatf("v%0d_valid", i), 64'(rd_valid),    64'(vecs[i].e_valid));
      check($sformatf("v%0d_rd_ptr", i), 64'(rd_ptr),     64'(vecs[i].e_rd_ptr));
      check($sformatf("v%0d_en", i),    64'(mem_rd_en),   64'(vecs[i].e_en));
      check($sformatf("v%0d_addr", i),  64'(mem_rd_addr), 64'(vecs[i].e_addr));
      check($sformatf("v%0d_fill", i),  64'(fill_count),  64'(vecs[i].e_fill));
      check($sformatf("v%0d_empty", i), 64'(empty_flag),  64'(vecs[i].e_empty));
      if (vecs[i].chk_data != 0) check($sformatf("v%0d_data", i), rd_data, vecs[i].e_data);
    end

    // Back-to-back gathers with the request held high.
    step(1, 0, 0);
    n = 0;
    step(0, 8, 1);
    while (!rd_valid && n < 20) begin n++; step(0, 8, 1); end
    check("b2b_first_valid", 64'(rd_valid), 64'd1);
    check("b2b_first_word", rd_data, W0);
    low = 0;
    step(0, 8, 1);
    while (!rd_valid && low < 20) begin low++; step(0, 8, 1); end
    check("b2b_gap_cycles", 64'(low), 64'd5);
    check("b2b_second_word", rd_data, W1);
    step(0, 8, 1);
    step(0, 8, 1);
    check("b2b_end_valid", 64'(rd_valid), 64'd0);
    check("b2b_end_rd_ptr", 64'(rd_ptr), 64'd8);
    check("b2b_end_empty", 64'(empty_flag), 64'd1);

    // Address and pointer wrap: rd_ptr 8 -> 20 (0b10100) across address 15 -> 0.
    for (int i = 0; i < 16; i++) mem[i] = 16'hA000 + 16'(i);
    exp_addr = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15,
                 4'd0, 4'd1, 4'd2, 4'd3};
    exp_word = '{64'hA00B_A00A_A009_A008, 64'hA00F_A00E_A00D_A00C,
                 64'hA003_A002_A001_A000};
    for (int k = 0; k < 24; k++) begin
      step(0, 20, 1);
      if (mem_rd_en) addrs.push_back(mem_rd_addr);
      if (rd_valid) words.push_back(rd_data);
    end
    check("wrap_addr_count", 64'(addrs.size()), 64'd12);
    for (int i = 0; i < 12; i++)
      if (i < addrs.size()) check($sformatf("wrap_addr%0d", i), 64'(addrs[i]), 64'(exp_addr[i]));
    check("wrap_word_count", 64'(words.size()), 64'd3);
    for (int i = 0; i < 3; i++)
      if (i < words.size()) check($sformatf("wrap_word%0d", i), words[i], exp_word[i]);
    check("wrap_rd_ptr", 64'(rd_ptr), 64'b10100);
    check("wrap_fill", 64'(fill_count), 64'd0);

    // Full FIFO, no consumer: exactly one gather, then wait for a pop.
    mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
    step(1, 0, 0);
    en_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      step(0, 16, 0);
      if (mem_rd_en) en_cnt++;
      if (k == 2) check("full_fill_before_capture", 64'(fill_count), 64'd16);
      if (k == 3) check("full_fill_after_capture", 64'(fill_count), 64'd15);
    end
    check("full_issue_count", 64'(en_cnt), 64'd4);
    check("full_valid", 64'(rd_valid), 64'd1);
    check("full_word", rd_data, W0);
    check("full_rd_ptr", 64'(rd_ptr), 64'd4);
    check("full_fill", 64'(fill_count), 64'd12);
    step(0, 16, 1);
    check("full_pop_valid", 64'(rd_valid), 64'd0);
    check("full_pop_refetch_en", 64'(mem_rd_en), 64'd1);
    check("full_pop_refetch_addr", 64'(mem_rd_addr), 64'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
